// File: rtl/approx_ctrl.sv
// Purpose: sequences the approximation datapath; optional watchdog via APPROX_CTRL_WATCHDOG_EN.
// Latency: start_i to done_o = 3 + (ALU_LAT+1)*(1+3k) cycles for k iterations; outputs registered.
// Backpressure: none; start_i is ignored while busy_o is high.
module approx_ctrl #(
    parameter int ALU_LAT = 2,
    parameter int MAX_IT  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       valid_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic       dp_start_o,
    output logic       check_for_termination_o,
    output logic [2:0] mode_o,
    output logic       wren_x1_o,
    output logic       wren_x1_n_o,
    output logic       wren_x1_n_mult_o,
    output logic       wren_y_o,
    output logic       wren_n_o,
    output logic       wren_sigma_n_o,
    output logic       x_to_alu_a_o,
    output logic       y_to_alu_a_o,
    output logic       x1_to_alu_a_o,
    output logic       n_to_alu_a_o,
    output logic       x1_n_to_alu_b_o,
    output logic       sigma_n_to_alu_o
);

    localparam int CW = $clog2(MAX_IT + 1);
    localparam logic [1:0] WAIT_LAST = (ALU_LAT >= 2) ? 2'(ALU_LAT - 2) : 2'd0;
`ifdef APPROX_CTRL_WATCHDOG_EN
    localparam logic [CW-1:0] MAX_IT_C = CW'(MAX_IT);
`endif

    localparam logic [2:0] MODE_PASS = 3'd0;
    localparam logic [2:0] MODE_DEC  = 3'd1;
    localparam logic [2:0] MODE_INC  = 3'd2;
    localparam logic [2:0] MODE_MUL  = 3'd3;
    localparam logic [2:0] MODE_ACC  = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_SETTLE,
        S_X1,
        S_POW,
        S_ACC,
        S_INC,
        S_DONE
`ifdef APPROX_CTRL_WATCHDOG_EN
        , S_ERR
`endif
    } state_t;

    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_WAIT,
        PH_WB
    } phase_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic       dp_start;
        logic       check;
        logic [2:0] mode;
        logic       wren_x1;
        logic       wren_x1_n;
        logic       wren_x1_n_mult;
        logic       wren_y;
        logic       wren_n;
        logic       wren_sigma_n;
        logic       x_a;
        logic       y_a;
        logic       x1_a;
        logic       n_a;
        logic       x1_n_b;
        logic       sigma_n;
    } ctrl_t;

    state_t          state, state_nxt;
    phase_t          phase, phase_nxt;
    logic [1:0]      wcnt, wcnt_nxt;
    logic            first_it, first_nxt;
    logic [CW-1:0]   iter_cnt, iter_nxt, iter_inc;
    ctrl_t           ctrl_q;

    // Routing and mode depend only on the state; write enables only fire in WB.
    function automatic ctrl_t decode(state_t st, phase_t ph, logic first);
        ctrl_t c;
        logic  wb;
        c      = '0;
        wb     = (ph == PH_WB);
        c.busy = (st != S_IDLE);
        case (st)
            S_START: c.dp_start = 1'b1;
            S_X1: begin
                c.x_a     = 1'b1;
                c.mode    = MODE_DEC;
                c.wren_x1 = wb;
            end
            S_POW: begin
                c.x1_a = 1'b1;
                if (first) begin
                    c.mode      = MODE_PASS;
                    c.wren_x1_n = wb;
                end else begin
                    c.x1_n_b         = 1'b1;
                    c.mode           = MODE_MUL;
                    c.wren_x1_n_mult = wb;
                end
            end
            S_ACC: begin
                c.y_a     = 1'b1;
                c.x1_n_b  = 1'b1;
                c.sigma_n = 1'b1;
                c.mode    = MODE_ACC;
                c.wren_y  = wb;
            end
            S_INC: begin
                c.n_a          = 1'b1;
                c.mode         = MODE_INC;
                c.wren_n       = wb;
                c.wren_sigma_n = wb;
                c.check        = wb;
            end
            S_DONE: c.done = 1'b1;
`ifdef APPROX_CTRL_WATCHDOG_EN
            S_ERR: c.err = 1'b1;
`endif
            default: ;
        endcase
        return c;
    endfunction

    // Saturating so the counter never wraps during an unbounded run.
    assign iter_inc = (iter_cnt == '1) ? iter_cnt : iter_cnt + CW'(1);

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        wcnt_nxt  = wcnt;
        first_nxt = first_it;
        iter_nxt  = iter_cnt;
        case (state)
            S_IDLE: begin
                if (start_i) state_nxt = S_START;
            end
            S_START: begin
                state_nxt = S_SETTLE;
                iter_nxt  = '0;
                first_nxt = 1'b1;
            end
            S_SETTLE: begin
                state_nxt = S_X1;
                phase_nxt = PH_ISSUE;
            end
            S_DONE: state_nxt = S_IDLE;
`ifdef APPROX_CTRL_WATCHDOG_EN
            S_ERR: state_nxt = S_IDLE;
`endif
            default: begin
                case (phase)
                    PH_ISSUE: begin
                        wcnt_nxt  = '0;
                        phase_nxt = (ALU_LAT == 1) ? PH_WB : PH_WAIT;
                    end
                    PH_WAIT: begin
                        if (wcnt == WAIT_LAST) phase_nxt = PH_WB;
                        else                   wcnt_nxt  = wcnt + 2'd1;
                    end
                    default: begin
                        phase_nxt = PH_ISSUE;
                        case (state)
                            S_X1:  state_nxt = S_POW;
                            S_POW: begin
                                state_nxt = S_ACC;
                                first_nxt = 1'b0;
                            end
                            S_ACC: state_nxt = S_INC;
                            default: begin
                                iter_nxt = iter_inc;
                                if (valid_i) state_nxt = S_DONE;
`ifdef APPROX_CTRL_WATCHDOG_EN
                                else if (iter_inc == MAX_IT_C) state_nxt = S_ERR;
`endif
                                else state_nxt = S_POW;
                            end
                        endcase
                    end
                endcase
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            phase    <= PH_ISSUE;
            wcnt     <= '0;
            first_it <= 1'b0;
            iter_cnt <= '0;
            ctrl_q   <= '0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            wcnt     <= wcnt_nxt;
            first_it <= first_nxt;
            iter_cnt <= iter_nxt;
            ctrl_q   <= decode(state_nxt, phase_nxt, first_nxt);
        end
    end

    assign busy_o                  = ctrl_q.busy;
    assign done_o                  = ctrl_q.done;
    assign err_o                   = ctrl_q.err;
    assign dp_start_o              = ctrl_q.dp_start;
    assign check_for_termination_o = ctrl_q.check;
    assign mode_o                  = ctrl_q.mode;
    assign wren_x1_o               = ctrl_q.wren_x1;
    assign wren_x1_n_o             = ctrl_q.wren_x1_n;
    assign wren_x1_n_mult_o        = ctrl_q.wren_x1_n_mult;
    assign wren_y_o                = ctrl_q.wren_y;
    assign wren_n_o                = ctrl_q.wren_n;
    assign wren_sigma_n_o          = ctrl_q.wren_sigma_n;
    assign x_to_alu_a_o            = ctrl_q.x_a;
    assign y_to_alu_a_o            = ctrl_q.y_a;
    assign x1_to_alu_a_o           = ctrl_q.x1_a;
    assign n_to_alu_a_o            = ctrl_q.n_a;
    assign x1_n_to_alu_b_o         = ctrl_q.x1_n_b;
    assign sigma_n_to_alu_o        = ctrl_q.sigma_n;

endmodule

// File: doc/approx_ctrl.md
APPROX_CTRL -- requirements
Module: approx_ctrl

Interface
REQ-001 Parameter ALU_LAT, default 2, cycles from operand select to result on the datapath writeback bus (range 1..4).
REQ-002 Parameter MAX_IT, default 8, iteration limit used by the watchdog (REQ-031).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start_i  input  1  request to begin one approximation run.
REQ-006 valid_i  input  1  datapath termination flag (n written back equals iteration count).
REQ-007 busy_o  output  1  high in every state except IDLE.
REQ-008 done_o  output  1  one-cycle pulse at run completion.
REQ-009 err_o  output  1  one-cycle pulse on watchdog abort.
REQ-010 dp_start_o  output  1  datapath start/initialise pulse.
REQ-011 check_for_termination_o  output  1  enables datapath termination compare.
REQ-012 mode_o  output  3  ALU operation select.
REQ-013 wren_x1_o, wren_x1_n_o, wren_x1_n_mult_o, wren_y_o, wren_n_o, wren_sigma_n_o  output  1 each  datapath register write enables.
REQ-014 x_to_alu_a_o, y_to_alu_a_o, x1_to_alu_a_o, n_to_alu_a_o, x1_n_to_alu_b_o, sigma_n_to_alu_o  output  1 each  datapath operand routing.

Function
REQ-015 ALU mode encoding: 0 PASS (a), 1 DEC (a-1), 2 INC (a+1), 3 MUL (a*b, Q4 result), 4 ACC (a+b if sigma=0, a-b if sigma=1); 5-7 never driven.
REQ-016 States: IDLE, START, SETTLE, X1, POW, ACC, INC, DONE, plus ERR when the watchdog is compiled in.
REQ-017 Each ALU operation state has three phases:
- ISSUE: 1 cycle.
- WAIT: ALU_LAT-1 cycles.
- WB: 1 cycle.
- Routing selects and mode_o are held constant through all three phases.
- The write enable(s) are high only in WB.
REQ-018 IDLE: all outputs 0; start_i=1 moves to START next cycle; start_i is ignored in every other state.
REQ-019 START: dp_start_o=1 for exactly one cycle, then SETTLE (1 cycle, all strobes 0), then X1.
REQ-020 X1: x_to_alu_a_o=1, mode DEC; WB asserts wren_x1_o; next state POW.
REQ-021 POW, first iteration: x1_to_alu_a_o=1, mode PASS; WB asserts wren_x1_n_o.
REQ-022 POW, later iterations: x1_to_alu_a_o=1, x1_n_to_alu_b_o=1, mode MUL; WB asserts wren_x1_n_mult_o.
REQ-023 ACC: y_to_alu_a_o=1, x1_n_to_alu_b_o=1, sigma_n_to_alu_o=1, mode ACC; WB asserts wren_y_o.
REQ-024 INC: n_to_alu_a_o=1, mode INC; WB asserts wren_n_o, wren_sigma_n_o and check_for_termination_o together.
REQ-025 valid_i is sampled only in the INC WB cycle: 1 goes to DONE, 0 goes to POW (not-first iteration); valid_i in any other cycle is ignored.
REQ-026 DONE: done_o=1 for one cycle, then IDLE.
REQ-027 Two one-hot groups are mutually exclusive per cycle: at most one write enable, except the INC WB pair (wren_n_o, wren_sigma_n_o); at most one of x/y/x1/n_to_alu_a_o.
REQ-028 Latency with ALU_LAT=2, from the cycle start_i is sampled to done_o: 6 + 9*k cycles, where k is the number of completed iterations (k=1 gives 15).
REQ-029 An internal iteration counter of ceil(log2(MAX_IT+1)) bits clears in START and increments at each INC WB.

Reset
REQ-030 rst=1 at any clock edge, including mid-run, forces IDLE and clears the iteration counter and first-iteration flag; all outputs are 0 in the following cycle and no done_o or err_o is issued for the aborted run.

Configuration
REQ-031 With macro APPROX_CTRL_WATCHDOG_EN defined:
- An INC WB with valid_i=0 and iteration counter equal to MAX_IT goes to ERR.
- ERR pulses err_o for one cycle, then returns to IDLE.
- This covers runs where termination is never reached, e.g. iteration count 0 or 1.
REQ-032 Without APPROX_CTRL_WATCHDOG_EN:
- The ERR state and the watchdog compare are not built.
- err_o is tied to 0.
- The controller loops until valid_i is seen.

Verification
REQ-033 ALU_LAT=2, pulse start_i, valid_i=1 at first INC WB -> dp_start_o one cycle after sample; wren_x1_o at cycle 5; done_o at cycle 15, single cycle.
REQ-034 valid_i=1 only at third INC WB -> exactly one wren_x1_n_o and two wren_x1_n_mult_o pulses, three wren_y_o pulses; done_o at cycle 33.
REQ-035 Every cycle of every run -> mode_o in 0..4 and selects stable across ISSUE..WB; REQ-027 exclusivity never violated.
REQ-036 start_i held high throughout a run -> no restart while busy; a new run begins only after done_o returns to IDLE.
REQ-037 rst asserted during ACC WAIT -> next cycle IDLE, all outputs 0, no done_o; a new start_i runs normally.
REQ-038 Watchdog compiled in, MAX_IT=8, valid_i held 0 -> err_o pulse at the 8th INC WB+1, done_o never asserted; without the macro, 20 iterations run and err_o stays 0.
